// File: rtl/ps2_receiver_pkg.sv
// PS/2 receiver shared definitions: scancode type, receive FSM encoding, parity helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_receiver_pkg;

   localparam int PS2_DATA_BITS = 8;

   typedef logic [PS2_DATA_BITS-1:0] scancode_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } rx_state_e;

   // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
   function automatic logic parity_ok(input scancode_t dat, input logic par);
      return ^{dat, par};
   endfunction

endpackage

// File: rtl/ps2_receiver_sync_fifo.sv
// Generic first-word-fall-through FIFO with sticky overflow flag.
// Latency: push visible at rd_data/count on the edge after push; pop advances head on its edge.
// Backpressure: none upstream; a push into a full FIFO (without a same-cycle pop) is dropped and sets overflow.
//
// Ports: push/push_dat write side; pop consumes head (ignored when empty);
//        clear_overflow clears the sticky flag (a same-cycle new overflow wins);
//        rd_data is the head (zero when empty), empty/count report occupancy.
module ps2_receiver_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   input  logic                     clear_overflow,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             overflow_q;
   logic             full;
   logic             pop_ok;
   logic             push_ok;
   logic             ovf_set;

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_ok  = pop && !empty;
   // A same-cycle pop frees the slot being written, so a full FIFO can still accept.
   assign push_ok = push && (!full || pop_ok);
   assign ovf_set = push && full && !pop_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (ovf_set)             overflow_q <= 1'b1;
         else if (clear_overflow) overflow_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
   end

   assign rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign count    = wr_ptr_q - rd_ptr_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard frame receiver: sync pins, decode start/8 data/odd parity/stop, queue good scancodes.
// Latency: pin edge to FSM action 3 clk edges; stop-bit fall to FIFO write 1 further cycle.
// Backpressure: none toward the keyboard; bytes arriving while the FIFO is full are dropped (sticky overflow).
//
// Ports: clk/reset (async active-low); ps2_clock/ps2_data raw pins; pop/clear_overflow from io;
//        rd_data/not_empty/count/overflow FIFO status; frame_error one-cycle pulse per discarded frame.
module ps2_receiver
   import ps2_receiver_pkg::*;
#(
   parameter int DEPTH          = 8,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ps2_clock,
   input  logic                     ps2_data,
   input  logic                     pop,
   input  logic                     clear_overflow,
   output logic [7:0]               rd_data,
   output logic                     not_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     frame_error
);

   localparam int               TW       = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       LAST_BIT = 4'(PS2_DATA_BITS - 1);

   logic          clk_s1_q, clk_s2_q, clk_prev_q;
   logic          dat_s1_q, dat_s2_q;
   logic          fall;
   rx_state_e     state_q;
   logic [3:0]    bit_cnt_q;
   scancode_t     shift_q;
   logic          parity_q;
   logic [TW-1:0] tmo_q;
   logic          push_q;
   logic          frame_error_q;
   logic          fifo_empty;

   // Synchronisers idle high so reset never fabricates a falling edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         clk_s1_q   <= ps2_clock;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_data;
         dat_s2_q   <= dat_s1_q;
      end
   end

   assign fall = clk_prev_q && !clk_s2_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         parity_q      <= 1'b0;
         tmo_q         <= '0;
         push_q        <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         push_q        <= 1'b0;
         frame_error_q <= 1'b0;

         if (fall || state_q == ST_IDLE) tmo_q <= '0;
         else                            tmo_q <= tmo_q + 1'b1;

         case (state_q)
            ST_IDLE: begin
               // A falling edge with data high is noise, not a start bit.
               if (fall && !dat_s2_q) begin
                  state_q   <= ST_DATA;
                  bit_cnt_q <= '0;
               end
            end
            ST_DATA: begin
               if (fall) begin
                  shift_q   <= {dat_s2_q, shift_q[PS2_DATA_BITS-1:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == LAST_BIT) state_q <= ST_PARITY;
               end
            end
            ST_PARITY: begin
               if (fall) begin
                  parity_q <= dat_s2_q;
                  state_q  <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (fall) begin
                  state_q <= ST_IDLE;
                  if (dat_s2_q && parity_ok(shift_q, parity_q)) push_q <= 1'b1;
                  else                                           frame_error_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         // Stalled keyboard: abandon the partial frame so the next start bit resyncs.
         if (!fall && state_q != ST_IDLE && tmo_q == TMO_LAST) begin
            state_q       <= ST_IDLE;
            tmo_q         <= '0;
            frame_error_q <= 1'b1;
         end
      end
   end

   // shift_q only moves in ST_DATA, so it still holds the byte while push_q is high.
   ps2_receiver_sync_fifo #(
      .WIDTH (PS2_DATA_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk            (clk),
      .reset          (reset),
      .push           (push_q),
      .push_dat       (shift_q),
      .pop            (pop),
      .clear_overflow (clear_overflow),
      .rd_data        (rd_data),
      .empty          (fifo_empty),
      .count          (count),
      .overflow       (overflow)
   );

   assign not_empty   = !fifo_empty;
   assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_receiver.sv
module tb_ps2_receiver;

   localparam int DEPTH = 8;
   localparam int HALF  = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2_clock;
   logic       ps2_data;
   logic       pop;
   logic       clear_overflow;
   logic [7:0] rd_data;
   logic       not_empty;
   logic [3:0] count;
   logic       overflow;
   logic       frame_error;

   int         checks   = 0;
   int         failures = 0;
   int         err_pulses = 0;
   logic [7:0] sb[$];
   logic       exp_ovf = 1'b0;

   ps2_receiver #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(10000)) dut (
      .clk            (clk),
      .reset          (reset),
      .ps2_clock      (ps2_clock),
      .ps2_data       (ps2_data),
      .pop            (pop),
      .clear_overflow (clear_overflow),
      .rd_data        (rd_data),
      .not_empty      (not_empty),
      .count          (count),
      .overflow       (overflow),
      .frame_error    (frame_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_error === 1'b1) err_pulses++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clock = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clock = 1'b1;
   endtask

   // Full 11-bit frame; pop_on_stop raises pop exactly on the cycle the byte is written.
   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_v,
                             input logic pop_on_stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit((~^d) ^ par_flip);
      ps2_data = stop_v;
      repeat (HALF) @(negedge clk);
      ps2_clock = 1'b0;
      if (pop_on_stop) begin
         repeat (3) @(negedge clk);
         pop = 1'b1;
         @(negedge clk);
         pop = 1'b0;
         repeat (HALF - 4) @(negedge clk);
      end else begin
         repeat (HALF) @(negedge clk);
      end
      ps2_clock = 1'b1;
      ps2_data  = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic send_good(input logic [7:0] d);
      send_frame(d, 1'b0, 1'b1, 1'b0);
      if (sb.size() < DEPTH) sb.push_back(d);
      else                   exp_ovf = 1'b1;
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] exp;
      exp = (sb.size() > 0) ? sb.pop_front() : 8'h00;
      check(tag, rd_data, exp);
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int e0;
      int waited;
      logic [7:0] head;

      reset = 1'b0; ps2_clock = 1'b1; ps2_data = 1'b1; pop = 1'b0; clear_overflow = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_not_empty", not_empty, 1'b0);
      check("rst_count", count, 0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_frame_error", frame_error, 1'b0);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      // Good frame
      e0 = err_pulses;
      send_good(8'h1C);
      check("good_not_empty", not_empty, 1'b1);
      check("good_count", count, sb.size());
      check("good_no_err", err_pulses - e0, 0);
      pop_check("good_rd_data");
      check("good_pop_not_empty", not_empty, 1'b0);
      check("good_pop_rd_data", rd_data, 8'h00);
      pop = 1'b1; @(negedge clk); pop = 1'b0; @(negedge clk);
      check("pop_empty_count", count, 0);

      // Bad parity, then a good byte
      e0 = err_pulses;
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
      check("badpar_err", err_pulses - e0, 1);
      check("badpar_count", count, 0);
      send_good(8'hF0);
      check("after_badpar_count", count, 1);
      pop_check("after_badpar_rd");

      // Bad stop bit
      e0 = err_pulses;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      check("badstop_err", err_pulses - e0, 1);
      check("badstop_count", count, 0);

      // Fill and overflow
      for (int i = 1; i <= 9; i++) send_good(8'(i));
      check("fill_count", count, DEPTH);
      check("fill_overflow", overflow, exp_ovf);
      for (int i = 0; i < DEPTH; i++) pop_check("fill_pop");
      check("fill_drained", not_empty, 1'b0);
      check("fill_ovf_sticky", overflow, 1'b1);
      clear_overflow = 1'b1; @(negedge clk); clear_overflow = 1'b0; @(negedge clk);
      exp_ovf = 1'b0;
      check("clear_overflow", overflow, exp_ovf);

      // Full with simultaneous push and pop
      for (int i = 0; i < DEPTH; i++) send_good(8'h11 + 8'(i));
      check("full_count", count, DEPTH);
      head = sb.pop_front();
      check("full_head", rd_data, head);
      sb.push_back(8'h55);
      send_frame(8'h55, 1'b0, 1'b1, 1'b1);
      check("simul_count", count, DEPTH);
      check("simul_overflow", overflow, 1'b0);
      for (int i = 0; i < DEPTH; i++) pop_check("simul_pop");
      check("simul_drained", count, 0);

      // Timeout after start + 3 data bits
      e0 = err_pulses;
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
      ps2_data = 1'b1;
      waited = 0;
      while (err_pulses == e0 && waited < 12000) begin
         @(negedge clk);
         waited++;
      end
      check("timeout_err", err_pulses - e0, 1);
      check("timeout_window", (waited >= 9980 && waited <= 10010), 1'b1);
      check("timeout_count", count, 0);
      repeat (4) @(negedge clk);
      send_good(8'h29);
      pop_check("after_timeout_rd");

      // Reset mid-frame with two bytes queued
      send_good(8'h33);
      send_good(8'h44);
      check("premid_count", count, 2);
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      ps2_data = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clock = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_count", count, 0);
      check("midrst_overflow", overflow, 1'b0);
      check("midrst_not_empty", not_empty, 1'b0);
      check("midrst_rd_data", rd_data, 8'h00);
      sb.delete();
      exp_ovf = 1'b0;
      @(negedge clk);
      ps2_clock = 1'b1; ps2_data = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (2 * HALF) @(negedge clk);
      send_good(8'h5A);
      check("postrst_count", count, 1);
      pop_check("postrst_rd");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
